// File: rtl/serial_bit_source.sv
// serial_bit_source: accepts WIDTH-bit words on valid/ready and emits them one bit per clock on registered x/x_valid.
// Defining SER_PARITY_EN appends one even-parity bit per word.
module serial_bit_source #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy
);

  localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             accept;
`ifdef SER_PARITY_EN
  logic             par_q, par_d;
`endif

  // Ready depends only on state and counter so no combinational path runs din_valid -> din_ready.
  always_comb begin
    din_ready = 1'b0;
    case (state_q)
      IDLE:   din_ready = 1'b1;
`ifdef SER_PARITY_EN
      PARITY: din_ready = 1'b1;
`else
      SHIFT:  din_ready = (cnt_q == LAST);
`endif
      default: din_ready = 1'b0;
    endcase
  end

  assign accept = din_valid && din_ready;

  // x_q always holds the bit on the wire this cycle; sh_q keeps the word aligned so the next bit is at a fixed index.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    x_d       = 1'b0;
    x_valid_d = 1'b0;
`ifdef SER_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      SHIFT: begin
        if (cnt_q != LAST) begin
          cnt_d     = cnt_q + 1'b1;
          sh_d      = (MSB_FIRST != 0) ? (sh_q << 1) : (sh_q >> 1);
          x_d       = (MSB_FIRST != 0) ? sh_q[WIDTH-2] : sh_q[1];
          x_valid_d = 1'b1;
        end else begin
          cnt_d = '0;
`ifdef SER_PARITY_EN
          state_d   = PARITY;
          x_d       = par_q;
          x_valid_d = 1'b1;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // A word accepted in IDLE or in the final bit cycle starts on the very next cycle.
    if (accept) begin
      state_d   = SHIFT;
      cnt_d     = '0;
      sh_d      = din;
      x_d       = (MSB_FIRST != 0) ? din[WIDTH-1] : din[0];
      x_valid_d = 1'b1;
`ifdef SER_PARITY_EN
      par_d     = ^din;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
`ifdef SER_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
`ifdef SER_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign busy    = x_valid_q;

endmodule

// File: tb/tb_serial_bit_source.sv
// Bench for serial_bit_source: MSB-first and LSB-first instances share stimulus; a bit-queue model predicts the wire.
module tb_serial_bit_source;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready, x, x_valid, busy;
  logic         din_ready_l, x_l, x_valid_l, busy_l;

  int n_vec = 0;
  int n_err = 0;

  bit q_m[$];
  bit q_l[$];
  bit exp_rdy;
  bit acc;

  always #5 clk = ~clk;

  serial_bit_source #(.WIDTH(W), .MSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .x(x), .x_valid(x_valid), .busy(busy)
  );

  serial_bit_source #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready_l), .x(x_l), .x_valid(x_valid_l), .busy(busy_l)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // The model is just the ordered list of bits still owed on the wire.
  task automatic push_word(input logic [W-1:0] d);
    for (int i = 0; i < W; i++) begin
      q_m.push_back(d[W-1-i]);
      q_l.push_back(d[i]);
    end
`ifdef SER_PARITY_EN
    q_m.push_back(($countones(d) % 2) == 1);
    q_l.push_back(($countones(d) % 2) == 1);
`endif
  endtask

  // Ready is expected exactly when nothing is owed beyond the bit now on the wire.
  task automatic sample();
    bit ev, eb, el;
    ev = (q_m.size() != 0);
    eb = 1'b0;
    el = 1'b0;
    if (ev) begin
      eb = q_m.pop_front();
      el = q_l.pop_front();
    end
    exp_rdy = (q_m.size() == 0);
    check_eq("x_msb", x, eb);
    check_eq("x_valid_msb", x_valid, ev);
    check_eq("busy_msb", busy, ev);
    check_eq("din_ready_msb", din_ready, exp_rdy);
    check_eq("x_lsb", x_l, el);
    check_eq("x_valid_lsb", x_valid_l, ev);
  endtask

  task automatic cycle(input bit v, input logic [W-1:0] d);
    din_valid = v;
    din       = d;
    acc       = v && exp_rdy;
    @(posedge clk);
    if (acc) push_word(d);
    #1;
    sample();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_x"}, x, 1'b0);
    check_eq({tag, "_x_valid"}, x_valid, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_din_ready"}, din_ready, 1'b1);
    check_eq({tag, "_x_valid_lsb"}, x_valid_l, 1'b0);
  endtask

  initial begin
    int rcnt, rpos, exp_pos;
    bit pend;
    rst       = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    exp_rdy   = 1'b1;
    acc       = 1'b0;
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 3; i++) cycle(1'b0, '0);

    // Single words: B2 gives 1,0,1,1,0,0,1,0 MSB-first and 0,1,0,0,1,1,0,1 LSB-first.
    cycle(1'b1, 8'hB2);
    for (int i = 0; i < 11; i++) cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h07);
    for (int i = 0; i < 11; i++) cycle(1'b0, 8'h00);

    // Back-to-back FF then 00 with din_valid held: ready pulses once, on the final bit of the first word.
    cycle(1'b1, 8'hFF);
    rcnt = din_ready ? 1 : 0;
    rpos = 0;
    pend = 1'b1;
`ifdef SER_PARITY_EN
    exp_pos = W;
`else
    exp_pos = W - 1;
`endif
    for (int k = 1; k < exp_pos + W; k++) begin
      cycle(pend, 8'h00);
      if (acc) pend = 1'b0;
      if (din_ready) begin
        rcnt++;
        rpos = k;
      end
    end
    check_eq("b2b_ready_pulses", rcnt, 1);
    check_eq("b2b_ready_pos", rpos, exp_pos);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00);

    // Asynchronous reset in mid-word: outputs clear without a clock edge, and nothing resumes.
    cycle(1'b1, 8'hA5);
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    q_m.delete();
    q_l.delete();
    exp_rdy = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) cycle(1'b0, 8'h00);

    // Random traffic; din changes every cycle, including while stalled.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, W'($urandom));
    end
    for (int i = 0; i < 12; i++) cycle(1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
